request_unit: RTL and testbench
===============================

# request_unit

Memory-request sequencer between the control unit and the instruction/data cache ports. It turns the control unit's per-instruction iREN/dREN/dWEN/RegWr/halt decode into a handshaked request sequence. It holds the fetch while a data access is outstanding and emits single-cycle PC-advance and register-writeback commit strobes. It also keeps a sticky halt, an illegal-request flag, and instruction/stall counters for the bench.

## Interface
Parameters:
- CNT_W, 32, width of instr_cnt and stall_cnt

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  control: instruction fetch enable (decode of current instruction)
- dREN  in  1  control: current instruction reads data memory
- dWEN  in  1  control: current instruction writes data memory
- RegWr  in  1  control: current instruction writes the register file
- halt  in  1  control: current instruction is HALT
- ihit  in  1  cache: instruction valid this cycle
- dhit  in  1  cache: data access complete this cycle
- imemREN  out  1  instruction read request
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- pc_en  out  1  one-cycle strobe: PC advances at this edge
- wb_en  out  1  one-cycle strobe: register-file write commits at this edge
- halt_out  out  1  sticky halted
- req_err  out  1  sticky: dREN and dWEN seen together
- instr_cnt  out  CNT_W  committed instructions, saturating
- stall_cnt  out  CNT_W  stall cycles, saturating

## Operation
FSM states (reqstate_t): FETCH, DATA, HALTED. Reset state is FETCH.
- FETCH
  - imemREN = iREN; dmemREN = dmemWEN = 0.
  - On ihit with halt=1: go to HALTED. No pc_en, no wb_en.
  - On ihit with dREN|dWEN: latch dren_q/dwen_q and rwr_q=RegWr, then go to DATA. No pc_en.
  - On ihit otherwise: pc_en=1, wb_en=RegWr, stay in FETCH.
  - dhit is ignored in FETCH.
- DATA
  - imemREN=0; dmemREN=dren_q; dmemWEN=dwen_q. Outputs come from latches, so they are stable even if control inputs change.
  - On dhit: pc_en=1, wb_en=rwr_q, clear latches, go to FETCH.
  - ihit is ignored in DATA.
- HALTED
  - All requests, pc_en and wb_en are 0. halt_out=1.
  - Absorbing: only RST exits this state.
- Illegal request: dREN&dWEN on the ihit that enters DATA. Latch dwen_q=1 and dren_q=0 (write wins) and set req_err (sticky).
- halt takes priority over dREN/dWEN on the same ihit.
- instr_cnt += 1 on every pc_en.
- stall_cnt += 1 each cycle in FETCH with imemREN&!ihit, and each cycle in DATA with !dhit.
- Both counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset (RST high at a rising edge):
  - state=FETCH; latches, halt_out, req_err, instr_cnt, stall_cnt all 0.
  - While RST=1 every output is 0, including imemREN.
- Reset mid-DATA or in HALTED: the cycle after RST deasserts is FETCH with a fresh fetch. The outstanding data request is dropped.
- pc_en, wb_en and dmemREN/dmemWEN (in DATA) are combinational from state, latches and hit inputs. They are valid within the hit cycle.
- All state, latch and counter updates happen on the rising CLK edge.
- Latency:
  - Non-memory instruction: commits in the ihit cycle; 0 added cycles with ihit=1.
  - Memory instruction: at least 2 cycles (ihit cycle, then the DATA cycle with dhit).
- Back-to-back memory instructions: after the dhit commit, FETCH re-requests on the next cycle. No bubble beyond the ihit wait.
- halt_out rises the cycle after the halt ihit and holds until reset.

## Structure
- reqstate_t (2-bit enum: FETCH, DATA, HALTED) is added to cpu_types_pkg.
- Sub-module sat_counter: parameterised CNT_W saturating incrementer with CLK, RST, inc and count ports. It is instantiated twice.
- The FSM, request latches and sticky flags live in request_unit.

## Test plan
- Reset then ihit=1, iREN=1, RegWr=1 for 3 cycles:
  - pc_en=wb_en=1 in each cycle.
  - instr_cnt=3, stall_cnt=0.
- Load with dREN=1, RegWr=1, ihit at cycle 1, dhit delayed 3 cycles:
  - dmemREN=1 for cycles 2–5, imemREN=0 throughout.
  - Single pc_en/wb_en at cycle 5; stall_cnt=3.
- Store with dWEN=1, RegWr=0, dhit in the first DATA cycle:
  - dmemWEN=1 for 1 cycle.
  - pc_en=1, wb_en=0.
- halt=1 with dREN=1 on ihit:
  - HALTED next cycle, halt_out=1, no dmemREN.
  - Further ihit/dhit produce no strobes.
- dREN=dWEN=1 on ihit:
  - dmemWEN=1, dmemREN=0 in DATA.
  - req_err=1, sticky past commit.
- RST asserted in the 2nd DATA cycle:
  - All outputs 0 during reset.
  - FETCH with imemREN=1 after deassert; counters 0.
- CNT_W=2 with 5 commits: instr_cnt holds at 3.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU types, including the request sequencer state
package cpu_types_pkg;
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2
  } reqstate_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: counter that increments on inc and holds at all-ones
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);
  logic [CNT_W-1:0] count_q;
  always_ff @(posedge CLK) begin
    if (RST) count_q <= '0;
    else if (inc && count_q != '1) count_q <= count_q + 1'b1;
  end
  assign count = count_q;
endmodule

// File: rtl/request_unit.sv
// request_unit: sequences fetch/data cache requests and emits PC-advance and writeback strobes
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             iREN,
  input  logic             dREN,
  input  logic             dWEN,
  input  logic             RegWr,
  input  logic             halt,
  input  logic             ihit,
  input  logic             dhit,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             wb_en,
  output logic             halt_out,
  output logic             req_err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  reqstate_t state_q;
  logic dren_q, dwen_q, rwr_q, err_q;
  logic fetch, data, plain, stall;
  logic [CNT_W-1:0] icnt, scnt;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      dren_q  <= 1'b0;
      dwen_q  <= 1'b0;
      rwr_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: if (ihit) begin
          if (halt) state_q <= HALTED;
          else if (dREN || dWEN) begin
            dren_q  <= dREN && !dWEN;
            dwen_q  <= dWEN;
            rwr_q   <= RegWr;
            err_q   <= err_q || (dREN && dWEN);
            state_q <= DATA;
          end
        end
        DATA: if (dhit) begin
          dren_q  <= 1'b0;
          dwen_q  <= 1'b0;
          rwr_q   <= 1'b0;
          state_q <= FETCH;
        end
        default: state_q <= HALTED;
      endcase
    end
  end
  // Every output is forced low while reset is held, even before the first edge.
  always_comb begin
    fetch     = !RST && state_q == FETCH;
    data      = !RST && state_q == DATA;
    plain     = fetch && ihit && !halt && !dREN && !dWEN;
    imemREN   = fetch && iREN;
    dmemREN   = data && dren_q;
    dmemWEN   = data && dwen_q;
    pc_en     = plain || (data && dhit);
    wb_en     = (plain && RegWr) || (data && dhit && rwr_q);
    stall     = (fetch && iREN && !ihit) || (data && !dhit);
    halt_out  = !RST && state_q == HALTED;
    req_err   = !RST && err_q;
    instr_cnt = RST ? '0 : icnt;
    stall_cnt = RST ? '0 : scnt;
  end
  sat_counter #(.CNT_W(CNT_W)) u_icnt (.CLK(CLK), .RST(RST), .inc(pc_en), .count(icnt));
  sat_counter #(.CNT_W(CNT_W)) u_scnt (.CLK(CLK), .RST(RST), .inc(stall), .count(scnt));
endmodule

// File: tb/tb_request_unit.sv
// tb_request_unit: directed checks of request_unit, plus a 2-bit counter instance for saturation
module tb_request_unit;
  logic CLK = 1'b0, RST, iREN, dREN, dWEN, RegWr, halt, ihit, dhit;
  logic imemREN, dmemREN, dmemWEN, pc_en, wb_en, halt_out, req_err;
  logic [31:0] instr_cnt, stall_cnt;
  logic s_imemREN, s_dmemREN, s_dmemWEN, s_pc_en, s_wb_en, s_halt_out, s_req_err;
  logic [1:0] s_instr_cnt, s_stall_cnt;
  int total = 0, bad = 0;
  always #5 CLK = ~CLK;
  request_unit #(.CNT_W(32)) dut (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .RegWr(RegWr),
    .halt(halt), .ihit(ihit), .dhit(dhit), .imemREN(imemREN), .dmemREN(dmemREN),
    .dmemWEN(dmemWEN), .pc_en(pc_en), .wb_en(wb_en), .halt_out(halt_out),
    .req_err(req_err), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
  );
  request_unit #(.CNT_W(2)) dut_s (
    .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .RegWr(RegWr),
    .halt(halt), .ihit(ihit), .dhit(dhit), .imemREN(s_imemREN), .dmemREN(s_dmemREN),
    .dmemWEN(s_dmemWEN), .pc_en(s_pc_en), .wb_en(s_wb_en), .halt_out(s_halt_out),
    .req_err(s_req_err), .instr_cnt(s_instr_cnt), .stall_cnt(s_stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic drive(input logic i_ren, d_ren, d_wen, rwr, hlt, ih, dh);
    {iREN, dREN, dWEN, RegWr, halt, ihit, dhit} = {i_ren, d_ren, d_wen, rwr, hlt, ih, dh};
    #1;
  endtask
  initial begin
    RST = 1'b1;
    drive(1, 0, 0, 1, 0, 1, 0);
    chk("rst_imem_pre", imemREN, 0);
    chk("rst_pc_pre", pc_en, 0);
    tick;
    tick;
    chk("rst_imem", imemREN, 0);
    chk("rst_pc", pc_en, 0);
    chk("rst_wb", wb_en, 0);
    chk("rst_icnt", instr_cnt, 0);
    chk("rst_halt", halt_out, 0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 0, 1, 0);
      chk($sformatf("alu_pc%0d", i), pc_en, 1);
      chk($sformatf("alu_wb%0d", i), wb_en, 1);
      chk($sformatf("alu_imem%0d", i), imemREN, 1);
      tick;
    end
    chk("alu_icnt", instr_cnt, 3);
    chk("alu_scnt", stall_cnt, 0);
    drive(1, 1, 0, 1, 0, 1, 0);
    chk("ld_c1_pc", pc_en, 0);
    chk("ld_c1_dren", dmemREN, 0);
    tick;
    for (int i = 2; i <= 4; i++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk($sformatf("ld_c%0d_dren", i), dmemREN, 1);
      chk($sformatf("ld_c%0d_imem", i), imemREN, 0);
      chk($sformatf("ld_c%0d_pc", i), pc_en, 0);
      tick;
    end
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("ld_c5_dren", dmemREN, 1);
    chk("ld_c5_imem", imemREN, 0);
    chk("ld_c5_pc", pc_en, 1);
    chk("ld_c5_wb", wb_en, 1);
    tick;
    chk("ld_scnt", stall_cnt, 3);
    chk("ld_icnt", instr_cnt, 4);
    drive(1, 0, 1, 0, 0, 1, 0);
    chk("st_c1_pc", pc_en, 0);
    tick;
    drive(1, 0, 0, 0, 0, 0, 1);
    chk("st_dwen", dmemWEN, 1);
    chk("st_dren", dmemREN, 0);
    chk("st_pc", pc_en, 1);
    chk("st_wb", wb_en, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("st_dwen_after", dmemWEN, 0);
    chk("st_icnt", instr_cnt, 5);
    chk("sat_icnt", s_instr_cnt, 3);
    chk("sat_scnt", s_stall_cnt, 3);
    drive(1, 1, 1, 1, 0, 1, 0);
    tick;
    drive(0, 0, 0, 0, 0, 0, 1);
    chk("ill_dwen", dmemWEN, 1);
    chk("ill_dren", dmemREN, 0);
    chk("ill_err", req_err, 1);
    chk("ill_pc", pc_en, 1);
    tick;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ill_err_sticky", req_err, 1);
    drive(1, 1, 0, 1, 0, 1, 0);
    tick;
    drive(1, 0, 0, 0, 0, 0, 0);
    tick;
    chk("rd2_dren", dmemREN, 1);
    RST = 1'b1;
    #1;
    chk("rd2_rst_dren", dmemREN, 0);
    chk("rd2_rst_imem", imemREN, 0);
    chk("rd2_rst_err", req_err, 0);
    chk("rd2_rst_icnt", instr_cnt, 0);
    tick;
    RST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_imem", imemREN, 1);
    chk("post_rst_dren", dmemREN, 0);
    chk("post_rst_icnt", instr_cnt, 0);
    chk("post_rst_scnt", stall_cnt, 0);
    chk("post_rst_err", req_err, 0);
    tick;
    drive(1, 1, 0, 1, 1, 1, 0);
    chk("hlt_pc", pc_en, 0);
    chk("hlt_wb", wb_en, 0);
    tick;
    drive(1, 1, 0, 1, 0, 1, 1);
    chk("hlt_out", halt_out, 1);
    chk("hlt_dren", dmemREN, 0);
    chk("hlt_imem", imemREN, 0);
    chk("hlt_pc2", pc_en, 0);
    chk("hlt_wb2", wb_en, 0);
    tick;
    chk("hlt_out2", halt_out, 1);
    chk("hlt_pc3", pc_en, 0);
    chk("hlt_icnt", instr_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
